// File: rtl/sync_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_pkg
//  Purpose  : Shared constants and helpers for the sync_filter input
//             conditioner (filter counter width, default/minimum depths).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sync_pkg;

  localparam int STAGE_MIN    = 2;
  localparam int STAGE_DEF    = 3;
  localparam int FILT_CNT_DEF = 4;

  // Width of the stability counter: clog2(filt_cnt), never below one bit so
  // that FILT_CNT=1 still has a (constant-zero) counter to compare against.
  function automatic int cnt_width(input int filt_cnt);
    int w;
    w = $clog2(filt_cnt);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_filter_ch.sv
`default_nettype none
// ============================================================================
//  Module   : sync_filter_ch
//  Purpose  : One channel of the input conditioner: STAGE-deep synchroniser,
//             stability filter (FILT_CNT consecutive disagreeing cycles needed
//             before the level changes) and registered rise/fall strobes.
//  Ports    : clk, rst (sync, active-high), din (async raw level),
//             dout (filtered level), rise / fall (one-cycle edge strobes)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   STAGE    = STAGE_DEF,
  parameter int   FILT_CNT = FILT_CNT_DEF,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(FILT_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

  logic [STAGE-1:0] sync_ff;
  logic             sync_s;
  logic [CW-1:0]    cnt;

  // Plain flop chain; no logic between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGE-2:0], din};
    end
  end

  assign sync_s = sync_ff[STAGE-1];

  // cnt counts consecutive cycles of disagreement; the level flips on the
  // FILT_CNT-th one, so any return to agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RST_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_s == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync_s;
        cnt  <= '0;
        rise <= sync_s;
        fall <= ~sync_s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_filter.sv
`default_nettype none
// ============================================================================
//  Module   : sync_filter
//  Purpose  : WIDTH-channel synchroniser + debounce filter + edge strobes for
//             asynchronous or noisy level inputs. Each channel is independent.
//  Ports    : clk, rst (sync, active-high), din[WIDTH] (async raw inputs),
//             dout[WIDTH] (filtered level), rise[WIDTH] / fall[WIDTH]
//             (one-cycle strobes aligned with the first cycle of new dout).
//             With SYNC_FILTER_STICKY_EN defined: chg_clr[WIDTH] input and
//             chg_sticky[WIDTH] output (latched change flags, set beats clear).
//  Revision : 1.0 - initial release
// ============================================================================
module sync_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter int               STAGE    = STAGE_DEF,
  parameter int               FILT_CNT = FILT_CNT_DEF,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
`ifdef SYNC_FILTER_STICKY_EN
  input  logic [WIDTH-1:0] chg_clr,
  output logic [WIDTH-1:0] chg_sticky,
`endif
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Elaboration-time legality checks.
  if (STAGE < STAGE_MIN) begin : g_bad_stage
    $error("sync_filter: STAGE must be >= %0d", STAGE_MIN);
  end
  if (FILT_CNT < 1) begin : g_bad_filt
    $error("sync_filter: FILT_CNT must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_ch #(
      .STAGE    (STAGE),
      .FILT_CNT (FILT_CNT),
      .RST_VAL  (RST_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .din  (din[i]),
      .dout (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

`ifdef SYNC_FILTER_STICKY_EN
  // A strobe in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_sticky <= '0;
    end else begin
      chg_sticky <= (chg_sticky & ~chg_clr) | rise | fall;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_filter
//  Purpose  : Self-checking bench for sync_filter (WIDTH=4, STAGE=3,
//             FILT_CNT=4). Two instances: RST_VAL=0 and RST_VAL=4'hF.
//             Optional sticky ports follow SYNC_FILTER_STICKY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_filter;

  localparam int W  = 4;
  localparam int ST = 3;
  localparam int FC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din, din2;
  logic [W-1:0] dout, rise, fall, dout2, rise2, fall2;
`ifdef SYNC_FILTER_STICKY_EN
  logic [W-1:0] clr, stk, stk2;
`endif

  always #5 clk = ~clk;

  sync_filter #(.WIDTH(W), .STAGE(ST), .FILT_CNT(FC), .RST_VAL(4'h0)) u_dut0 (
    .clk (clk), .rst (rst), .din (din),
`ifdef SYNC_FILTER_STICKY_EN
    .chg_clr (clr), .chg_sticky (stk),
`endif
    .dout (dout), .rise (rise), .fall (fall)
  );

  sync_filter #(.WIDTH(W), .STAGE(ST), .FILT_CNT(FC), .RST_VAL(4'hF)) u_dut1 (
    .clk (clk), .rst (rst), .din (din2),
`ifdef SYNC_FILTER_STICKY_EN
    .chg_clr (clr), .chg_sticky (stk2),
`endif
    .dout (dout2), .rise (rise2), .fall (fall2)
  );

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // ---------------------------------------------------------------- model
  // The synchronised value is simply din as sampled ST edges earlier (zero
  // until ST edges have passed since reset). The level flips when the last
  // FC synchronised samples since reset all disagree with it.
  logic [W-1:0] rv     [2];
  logic [W-1:0] dlog   [2][16];
  logic [W-1:0] slog   [2][16];
  logic [W-1:0] m_dout [2];
  logic [W-1:0] m_rise [2];
  logic [W-1:0] m_fall [2];
  logic [W-1:0] m_stk  [2];
  int           t   = 100;
  int           age = 0;
  logic [W-1:0] ms, md;
  bit           all_diff;

  always @(posedge clk) begin
    if (rst) begin
      age = 0;
      for (int u = 0; u < 2; u++) begin
        m_dout[u] = rv[u];
        m_rise[u] = '0;
        m_fall[u] = '0;
        m_stk[u]  = '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
`ifdef SYNC_FILTER_STICKY_EN
        m_stk[u] = (m_stk[u] & ~clr) | m_rise[u] | m_fall[u];
`endif
        ms = (age >= ST) ? dlog[u][(t - ST) % 16] : '0;
        slog[u][t % 16] = ms;
        dlog[u][t % 16] = (u == 0) ? din : din2;
        md = m_dout[u];
        m_rise[u] = '0;
        m_fall[u] = '0;
        for (int c = 0; c < W; c++) begin
          if (age + 1 >= FC) begin
            all_diff = 1'b1;
            for (int k = 0; k < FC; k++)
              if (slog[u][(t - k) % 16][c] == md[c]) all_diff = 1'b0;
            if (all_diff) begin
              m_dout[u][c] = ~md[c];
              m_rise[u][c] = ~md[c];
              m_fall[u][c] = md[c];
            end
          end
        end
      end
      age++;
    end
    t++;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dout0", int'(dout),  int'(m_dout[0]));
      chk("rise0", int'(rise),  int'(m_rise[0]));
      chk("fall0", int'(fall),  int'(m_fall[0]));
      chk("dout1", int'(dout2), int'(m_dout[1]));
      chk("rise1", int'(rise2), int'(m_rise[1]));
      chk("fall1", int'(fall2), int'(m_fall[1]));
`ifdef SYNC_FILTER_STICKY_EN
      chk("stk0", int'(stk),  int'(m_stk[0]));
      chk("stk1", int'(stk2), int'(m_stk[1]));
`endif
    end
  end

  // Observe one channel for n edges; report first edge index and count of
  // rise and fall strobes.
  task automatic watch(input int n, input int ch, input bit u1,
                       output int fr, output int rc, output int ffi, output int fcn);
    fr = 0; rc = 0; ffi = 0; fcn = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (u1 ? rise2[ch] : rise[ch]) begin rc++;  if (fr == 0)  fr = k;  end
      if (u1 ? fall2[ch] : fall[ch]) begin fcn++; if (ffi == 0) ffi = k; end
    end
  endtask

  int fr, rc, ffi, fcn, seen, hits, hold;

  initial begin
    rv[0] = 4'h0;
    rv[1] = 4'hF;
    rst = 1'b1; din = '0; din2 = '0;
`ifdef SYNC_FILTER_STICKY_EN
    clr = '0;
`endif
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_dout1", int'(dout2), 15);
    rst = 1'b0;

    // Idle with zero input: nothing moves on the RST_VAL=0 instance.
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if ((dout | rise | fall) != 0) seen++;
    end
    chk("idle_quiet", seen, 0);

    // Single rise on channel 0: visible after edge STAGE+FILT_CNT.
    @(negedge clk); din[0] = 1'b1;
    watch(12, 0, 1'b0, fr, rc, ffi, fcn);
    chk("rise0_edge", fr, 7);
    chk("rise0_count", rc, 1);
    chk("others_low", int'(dout[3:1]), 0);

    // 3-cycle glitch rejected, 4-cycle pulse accepted.
    @(negedge clk); din[1] = 1'b1;
    repeat (3) @(negedge clk); din[1] = 1'b0;
    watch(15, 1, 1'b0, fr, rc, ffi, fcn);
    chk("glitch3_strobes", rc + fcn, 0);
    chk("glitch3_dout", int'(dout[1]), 0);
    @(negedge clk); din[1] = 1'b1;
    repeat (4) @(negedge clk); din[1] = 1'b0;
    watch(20, 1, 1'b0, fr, rc, ffi, fcn);
    chk("pulse4_counts", rc * 10 + fcn, 11);
    chk("pulse4_spacing", ffi - fr, 4);

    // All channels together.
    @(negedge clk); din = '0;
    repeat (15) @(negedge clk);
    din = 4'hF;
    hits = 0; seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (rise == 4'hF) hits++;
      else if (rise != 0) seen++;
    end
    chk("all_rise_once", hits, 1);
    chk("all_rise_partial", seen, 0);

    // Reset while channel 2 is mid-count.
    @(negedge clk); din = '0;
    repeat (15) @(negedge clk);
    din[2] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midcnt_dout", int'(dout[2]), 0);
    chk("midcnt_rise", int'(rise[2]), 0);
    // RST_VAL=F with din=0: the cleared synchroniser already shows 0, so
    // only the FILT_CNT stability cycles remain before the fall.
    hits = 0; fr = 0; ffi = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (fall2 == 4'hF) begin hits++; if (ffi == 0) ffi = k; end
      if (rise[2] && fr == 0) fr = k;
    end
    chk("rstval_fall_edge", ffi, FC);
    chk("rstval_fall_once", hits, 1);
    chk("post_rst_rise_edge", fr, ST + FC);

    // Randomised traffic with occasional resets.
    hold = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (hold == 0) begin
        din  = 4'($urandom);
        din2 = 4'($urandom);
        hold = $urandom_range(1, 7);
      end else begin
        hold--;
      end
      rst = ($urandom_range(0, 299) == 0);
`ifdef SYNC_FILTER_STICKY_EN
      clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
`endif
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
